// File: rtl/vga_pkg.sv
// Shared constants for the VGA timing generator.
// Resolution set chosen by RES_720x400 / RES_720x480 (default 640x480@60).
package vga_pkg;

    localparam int CW   = 10;
    localparam int COLW = 4;

`ifdef RES_720x400
    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_H_FP     = 18;
    localparam int DEF_H_SYNC   = 108;
    localparam int DEF_H_BP     = 54;
    localparam int DEF_V_ACTIVE = 400;
    localparam int DEF_V_FP     = 12;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 35;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b1;
`elsif RES_720x480
    localparam int DEF_H_ACTIVE = 720;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 62;
    localparam int DEF_H_BP     = 60;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 9;
    localparam int DEF_V_SYNC   = 6;
    localparam int DEF_V_BP     = 30;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
`else
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam bit DEF_HS_POL   = 1'b0;
    localparam bit DEF_VS_POL   = 1'b0;
`endif

    function automatic int span_total(int a, int b, int c, int d);
        return a + b + c + d;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Fetch bus between the timing generator and the pixel renderer:
// coordinates and strobes out, colour back LATENCY cycles later.
interface vga_timing_gen_if;
    import vga_pkg::*;

    logic [CW-1:0]   x;
    logic [CW-1:0]   y;
    logic            fetch_de;
    logic            line_start;
    logic            frame_start;
    logic [COLW-1:0] pix_r;
    logic [COLW-1:0] pix_g;
    logic [COLW-1:0] pix_b;

    modport master (
        output x, y, fetch_de, line_start, frame_start,
        input  pix_r, pix_g, pix_b
    );

    modport slave (
        input  x, y, fetch_de, line_start, frame_start,
        output pix_r, pix_g, pix_b
    );

endinterface

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with a synchronous reset value.
// DEPTH = 0 degenerates to a plain wire.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] rst_val,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign q = d;
        end else begin : g_shift
            logic [WIDTH-1:0] stage [DEPTH];

            // Shift one stage per clock; reset loads every stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= rst_val;
                end else begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing, renderer fetch coordinates and pin-side output register.
// VGA_TESTPATTERN_EN replaces renderer colour with eight vertical bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = DEF_HS_POL,
    parameter bit VS_POL   = DEF_VS_POL,
    parameter int LATENCY  = 2
) (
    input  logic                clk_vga,
    input  logic                reset,
    vga_timing_gen_if.master    fetch,
    output logic [COLW-1:0]     r,
    output logic [COLW-1:0]     g,
    output logic [COLW-1:0]     b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de
);

    localparam int H_TOTAL = span_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = span_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h;
    logic [CW-1:0] v;
    logic          raw_de;
    logic          raw_hs;
    logic          raw_vs;
    logic          de_d;
    logic          hs_d;
    logic          vs_d;
    logic [COLW-1:0] col_r;
    logic [COLW-1:0] col_g;
    logic [COLW-1:0] col_b;

    // Raster counters: v steps on every h wrap, both wrap at frame end.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    assign fetch.x           = h;
    assign fetch.y           = v;
    assign fetch.fetch_de    = raw_de;
    assign fetch.line_start  = (h == '0);
    assign fetch.frame_start = (h == '0) && (v == '0);

    assign raw_de = (h < H_ACT) && (v < V_ACT);
    assign raw_hs = (h >= HS_BEG) && (h < HS_END);
    assign raw_vs = (v >= VS_BEG) && (v < VS_END);

    // Syncs are carried active-high internally; polarity applied at the pins.
    vga_delay_line #(
        .WIDTH (3),
        .DEPTH (LATENCY)
    ) u_ctl_dly (
        .clk     (clk_vga),
        .reset   (reset),
        .rst_val (3'b000),
        .d       ({raw_de, raw_hs, raw_vs}),
        .q       ({de_d, hs_d, vs_d})
    );

`ifdef VGA_TESTPATTERN_EN
    logic [CW-1:0] x_d;
    logic [2:0]    bar;

    vga_delay_line #(
        .WIDTH (CW),
        .DEPTH (LATENCY)
    ) u_x_dly (
        .clk     (clk_vga),
        .reset   (reset),
        .rst_val ('0),
        .d       (h),
        .q       (x_d)
    );

    assign bar   = 3'(x_d / CW'(H_ACTIVE / 8));
    assign col_r = {COLW{bar[2]}};
    assign col_g = {COLW{bar[1]}};
    assign col_b = {COLW{bar[0]}};
`else
    assign col_r = fetch.pix_r;
    assign col_g = fetch.pix_g;
    assign col_b = fetch.pix_b;
`endif

    // Pin register: blank colour outside the active area, apply sync polarity.
    always_ff @(posedge clk_vga) begin
        if (reset) begin
            r      <= '0;
            g      <= '0;
            b      <= '0;
            vga_de <= 1'b0;
            vga_hs <= ~HS_POL;
            vga_vs <= ~VS_POL;
        end else begin
            r      <= de_d ? col_r : '0;
            g      <= de_d ? col_g : '0;
            b      <= de_d ? col_b : '0;
            vga_de <= de_d;
            vga_hs <= hs_d ? HS_POL : ~HS_POL;
            vga_vs <= vs_d ? VS_POL : ~VS_POL;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a tiny LATENCY=0
// instance checked against vectors, hand sequences and an arithmetic model.
module tb_vga_timing_gen;
    import vga_pkg::*;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic fde, ls, fs, de, hs, vs;
        logic [3:0] r, g, b;
    } obs_t;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb, lat;
        bit hpol, vpol;
    } tim_t;

    typedef struct {
        int         t;
        logic [3:0] pix;
        obs_t       e;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_d, rst_s;
    logic [3:0] r_d, g_d, b_d, r_s, g_s, b_s;
    logic hs_d, vs_d, de_d, hs_s, vs_s, de_s;

    vga_timing_gen_if bus_d();
    vga_timing_gen_if bus_s();

    vga_timing_gen dut_d (
        .clk_vga (clk), .reset (rst_d), .fetch (bus_d),
        .r (r_d), .g (g_d), .b (b_d),
        .vga_hs (hs_d), .vga_vs (vs_d), .vga_de (de_d)
    );

    vga_timing_gen #(
        .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (3),
        .V_ACTIVE (6), .V_FP (2), .V_SYNC (2), .V_BP (3),
        .HS_POL (1'b1), .VS_POL (1'b1), .LATENCY (0)
    ) dut_s (
        .clk_vga (clk), .reset (rst_s), .fetch (bus_s),
        .r (r_s), .g (g_s), .b (b_s),
        .vga_hs (hs_s), .vga_vs (vs_s), .vga_de (de_s)
    );

    int checks = 0;
    int failures = 0;
    int td = 0;
    int ts = 0;
    logic [11:0] pd_prev = '0;
    logic [11:0] ps_prev = '0;
    tim_t pd, ps;
    vec_t vecs[13];

    // Expected outputs from cycle count t since reset release.
    function automatic obs_t model(tim_t p, int t, logic [11:0] pix);
        obs_t o;
        int ht, vt, n, hc, vc, hn, vn;
        ht = p.ha + p.hf + p.hs + p.hb;
        vt = p.va + p.vf + p.vs + p.vb;
        hc = t % ht;
        vc = (t / ht) % vt;
        o.x   = 10'(hc);
        o.y   = 10'(vc);
        o.fde = (hc < p.ha) && (vc < p.va);
        o.ls  = (hc == 0);
        o.fs  = (hc == 0) && (vc == 0);
        o.de  = 1'b0;
        o.hs  = !p.hpol;
        o.vs  = !p.vpol;
        {o.r, o.g, o.b} = 12'h000;
        n = t - p.lat - 1;
        if (n >= 0) begin
            hn = n % ht;
            vn = (n / ht) % vt;
            o.de = (hn < p.ha) && (vn < p.va);
            if (hn >= p.ha + p.hf && hn < p.ha + p.hf + p.hs) o.hs = p.hpol;
            if (vn >= p.va + p.vf && vn < p.va + p.vf + p.vs) o.vs = p.vpol;
            if (o.de) begin
`ifdef VGA_TESTPATTERN_EN
                logic [2:0] bar;
                bar = 3'(hn / (p.ha / 8));
                {o.r, o.g, o.b} = {{4{bar[2]}}, {4{bar[1]}}, {4{bar[0]}}};
`else
                {o.r, o.g, o.b} = pix;
`endif
            end
        end
        return o;
    endfunction

    function automatic obs_t obs_d();
        return {bus_d.x, bus_d.y, bus_d.fetch_de, bus_d.line_start,
                bus_d.frame_start, de_d, hs_d, vs_d, r_d, g_d, b_d};
    endfunction

    function automatic obs_t obs_s();
        return {bus_s.x, bus_s.y, bus_s.fetch_de, bus_s.line_start,
                bus_s.frame_start, de_s, hs_s, vs_s, r_s, g_s, b_s};
    endfunction

    function automatic vec_t mk(int t, logic [3:0] pix, int x, int y,
                                logic [5:0] fl, logic [3:0] c);
        vec_t v;
        v.t   = t;
        v.pix = pix;
        v.e   = {10'(x), 10'(y), fl, c, c, c};
        return v;
    endfunction

    task automatic check(string name, obs_t got, obs_t exp, int t);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got x=%0d y=%0d fde=%b ls=%b fs=%b de=%b hs=%b vs=%b rgb=%h%h%h required x=%0d y=%0d fde=%b ls=%b fs=%b de=%b hs=%b vs=%b rgb=%h%h%h",
                     name, t, got.x, got.y, got.fde, got.ls, got.fs, got.de,
                     got.hs, got.vs, got.r, got.g, got.b, exp.x, exp.y,
                     exp.fde, exp.ls, exp.fs, exp.de, exp.hs, exp.vs,
                     exp.r, exp.g, exp.b);
        end
    endtask

    task automatic check_val(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, exp);
        end
    endtask

    task automatic drive_d(logic [11:0] v);
        {bus_d.pix_r, bus_d.pix_g, bus_d.pix_b} = v;
    endtask

    task automatic drive_s(logic [11:0] v);
        {bus_s.pix_r, bus_s.pix_g, bus_s.pix_b} = v;
    endtask

    // One clock; track cycle counts and the colour each DUT sampled.
    task automatic tick();
        @(posedge clk);
        pd_prev = {bus_d.pix_r, bus_d.pix_g, bus_d.pix_b};
        ps_prev = {bus_s.pix_r, bus_s.pix_g, bus_s.pix_b};
        td = rst_d ? 0 : td + 1;
        ts = rst_s ? 0 : ts + 1;
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        obs_t exp;
        int n;

        pd = '{640, 16, 96, 48, 480, 10, 2, 33, 2, 1'b0, 1'b0};
        ps = '{16, 2, 4, 3, 6, 2, 2, 3, 0, 1'b1, 1'b1};

        vecs[0]  = mk(0,   4'hA, 0,   0, 6'b111011, 4'h0);
        vecs[1]  = mk(2,   4'hA, 2,   0, 6'b100011, 4'h0);
        vecs[2]  = mk(3,   4'hA, 3,   0, 6'b100111, 4'hA);
        vecs[3]  = mk(642, 4'hA, 642, 0, 6'b000111, 4'hA);
        vecs[4]  = mk(643, 4'hF, 643, 0, 6'b000011, 4'h0);
        vecs[5]  = mk(658, 4'hF, 658, 0, 6'b000011, 4'h0);
        vecs[6]  = mk(659, 4'hF, 659, 0, 6'b000001, 4'h0);
        vecs[7]  = mk(754, 4'hF, 754, 0, 6'b000001, 4'h0);
        vecs[8]  = mk(755, 4'hF, 755, 0, 6'b000011, 4'h0);
        vecs[9]  = mk(799, 4'hF, 799, 0, 6'b000011, 4'h0);
        vecs[10] = mk(800, 4'h5, 0,   1, 6'b110011, 4'h0);
        vecs[11] = mk(802, 4'h5, 2,   1, 6'b100011, 4'h0);
        vecs[12] = mk(803, 4'h5, 3,   1, 6'b100111, 4'h5);

        rst_d = 1'b1;
        rst_s = 1'b1;
        drive_d(12'hAAA);
        drive_s(12'h000);
        @(negedge clk);
        tick();
        tick();
        rst_d = 1'b0;

        // Vector table on the default instance.
        for (int i = 0; i < 13; i++) begin
            while (td < vecs[i].t) begin
                drive_d({3{vecs[i].pix}});
                tick();
            end
            exp = vecs[i].e;
`ifdef VGA_TESTPATTERN_EN
            begin
                obs_t m;
                m = model(pd, td, pd_prev);
                exp.r = m.r;
                exp.g = m.g;
                exp.b = m.b;
            end
`endif
            check("vec", obs_d(), exp, td);
        end

        // Reset mid-frame at h=300 of line 1.
        drive_d(12'hAAA);
        while (td < 1100) tick();
        check_val("de_before_reset", de_d, 1);
        rst_d = 1'b1;
        tick();
        check("mid_reset", obs_d(),
              {10'd0, 10'd0, 6'b111011, 12'h000}, td);
        rst_d = 1'b0;
        tick();
        tick();
        check_val("de_at_2", de_d, 0);
        tick();
        check_val("de_at_3", de_d, 1);

        // Reset inside hsync: the pulse must be cut, not stretched.
        while (td < 700) tick();
        check_val("hs_in_sync", hs_d, 0);
        rst_d = 1'b1;
        tick();
        check_val("hs_after_reset", hs_d, 1);
        rst_d = 1'b0;
        n = 0;
        while (td < 658) begin
            tick();
            if (hs_d == 1'b0) n++;
        end
        check_val("hs_no_stretch", n, 0);
        tick();
        check_val("hs_restart", hs_d, 0);

`ifdef VGA_TESTPATTERN_EN
        rst_d = 1'b1;
        tick();
        rst_d = 1'b0;
        while (td < 3) tick();
        check_val("bar_x0", {r_d, g_d, b_d}, 12'h000);
        while (td < 83) tick();
        check_val("bar_x80", {r_d, g_d, b_d}, 12'h00F);
        while (td < 563) tick();
        check_val("bar_x560", {r_d, g_d, b_d}, 12'hFFF);
`endif

        // Tiny LATENCY=0 instance: first pixel, frame and vsync timing.
        drive_s(12'h777);
        rst_s = 1'b0;
        check_val("lat0_de_t0", de_s, 0);
        tick();
        check_val("lat0_de_t1", de_s, 1);
        n = 0;
        while (!bus_s.frame_start && n < 1000) begin
            tick();
            n++;
        end
        n = 0;
        do begin
            tick();
            n++;
        end while (!bus_s.frame_start && n < 1000);
        check_val("frame_period", n, 325);
        n = 0;
        while (vs_s != 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check_val("vs_start", n, 201);
        n = 0;
        while (vs_s == 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check_val("vs_width", n, 50);

        // Random colour and sparse resets against the model.
        for (int i = 0; i < 6000; i++) begin
            check("rand_def", obs_d(), model(pd, td, pd_prev), td);
            check("rand_small", obs_s(), model(ps, ts, ps_prev), ts);
            drive_d(12'($urandom));
            drive_s(12'($urandom));
            rst_d = ($urandom_range(0, 1499) == 0);
            rst_s = ($urandom_range(0, 299) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
